// File: rtl/imm_sched_pkg.sv
// Shared types and field positions for the LEGv8 immediate scheduler.
package imm_sched_pkg;

  typedef enum logic [2:0] {
    FMT_I  = 3'd0,
    FMT_D  = 3'd1,
    FMT_B  = 3'd2,
    FMT_CB = 3'd3,
    FMT_IW = 3'd4
  } imm_fmt_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam int I_MSB  = 21;
  localparam int I_LSB  = 10;
  localparam int D_MSB  = 20;
  localparam int D_LSB  = 12;
  localparam int B_MSB  = 25;
  localparam int B_LSB  = 0;
  localparam int CB_MSB = 23;
  localparam int CB_LSB = 5;
  localparam int IW_MSB = 20;
  localparam int IW_LSB = 5;
  localparam int HW_MSB = 22;
  localparam int HW_LSB = 21;

  localparam int I_W  = I_MSB - I_LSB + 1;
  localparam int D_W  = D_MSB - D_LSB + 1;
  localparam int B_W  = B_MSB - B_LSB + 1;
  localparam int CB_W = CB_MSB - CB_LSB + 1;
  localparam int IW_W = IW_MSB - IW_LSB + 1;

endpackage

// File: rtl/imm_field_ext.sv
// Combinational immediate extraction and extension for one instruction word.
// Build option IMM_SCHED_BR_SHIFT_EN turns B/CB word offsets into byte offsets.
module imm_field_ext
  import imm_sched_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      fmt,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  logic [XLEN-1:0] br;
  logic [XLEN-1:0] iw;
  logic            unused_hi;

  assign unused_hi = ^instr[31:26];
  assign iw = {{(XLEN-IW_W){1'b0}}, instr[IW_MSB:IW_LSB]};

  always_comb begin
    imm = '0;
    err = 1'b0;
    br  = '0;
    case (fmt)
      FMT_I:  imm = {{(XLEN-I_W){1'b0}}, instr[I_MSB:I_LSB]};
      FMT_D:  imm = {{(XLEN-D_W){instr[D_MSB]}}, instr[D_MSB:D_LSB]};
      FMT_B, FMT_CB: begin
        if (fmt == FMT_B)
          br = {{(XLEN-B_W){instr[B_MSB]}}, instr[B_MSB:B_LSB]};
        else
          br = {{(XLEN-CB_W){instr[CB_MSB]}}, instr[CB_MSB:CB_LSB]};
`ifdef IMM_SCHED_BR_SHIFT_EN
        imm = {br[XLEN-3:0], 2'b00};
`else
        imm = br;
`endif
      end
      // Halfword select places the 16-bit chunk at bit 0/16/32/48.
      FMT_IW: imm = iw << {instr[HW_MSB:HW_LSB], 4'b0000};
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_sched.sv
// Round-robin arbiter feeding one shared immediate extender and a one-entry
// registered output slot. Build option IMM_SCHED_BR_SHIFT_EN (see imm_field_ext).
module imm_sched
  import imm_sched_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int N_REQ = 2,
  localparam int IDW  = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ-1:0][31:0] req_instr,
  input  logic [N_REQ-1:0][2:0] req_fmt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_imm,
  output logic [IDW-1:0]        out_id,
  output logic                  out_err,
  output state_e                dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. Requesters hold valid/payload until ready; out_* stay stable
  // while out_valid is high and out_ready is low.

  state_e          state;
  logic [IDW-1:0]  rr;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  idx;
  logic            found;
  logic            free;
  logic            grant;
  logic [XLEN-1:0] ext_imm;
  logic            ext_err;

  assign free = (state == ST_EMPTY) || out_ready;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = IDW'((int'(rr) + i) % N_REQ);
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  // Reset gating keeps the grant low during the reset cycle itself.
  assign grant     = found && free && reset_n;
  assign req_ready = grant ? (N_REQ'(1) << gnt_idx) : '0;

  imm_field_ext #(.XLEN(XLEN)) u_ext (
    .instr (req_instr[gnt_idx]),
    .fmt   (req_fmt[gnt_idx]),
    .imm   (ext_imm),
    .err   (ext_err)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_EMPTY;
      rr      <= IDW'(N_REQ - 1);
      out_imm <= '0;
      out_id  <= '0;
      out_err <= 1'b0;
    end else begin
      if (grant) begin
        rr      <= gnt_idx;
        out_imm <= ext_imm;
        out_id  <= gnt_idx;
        out_err <= ext_err;
      end
      case (state)
        ST_EMPTY: if (grant) state <= ST_FULL;
        ST_FULL:  if (out_ready && !grant) state <= ST_EMPTY;
        default:  state <= ST_EMPTY;
      endcase
    end
  end

  assign out_valid = (state == ST_FULL);
  assign dbg_state = state;

endmodule
